fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request and captures the fetch/decode (IF/ID) pipeline latch.
- Its latch outputs feed the decode stage, whose decoded results enter the decode/execute latch.
- Handles the blocking i-cache handshake (ihit), hazard-unit stall and flush, branch/jump redirect from a later stage, and halt.
- A redirect that arrives mid-miss is held pending, so the cache address never changes during a miss.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returns imemload for imemaddr this cycle.
- imemload  in  32  instruction word from memory.
- stall  in  1  hazard unit: hold PC and IF/ID latch.
- flush  in  1  squash IF/ID contents to a bubble.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  target PC for redirect.
- halt  in  1  halt reached downstream; stop fetching permanently.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  instruction address (always equals the current PC register).
- instr_ID  out  32  IF/ID latched instruction.
- imemaddr_ID  out  32  IF/ID latched PC of instr_ID.
- npc_ID  out  32  IF/ID latched PC+4.
- valid_ID  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (RST=1 at edge, any state):
  - pc=PC_INIT, state=RUN, pend_pc=0.
  - instr_ID=0, imemaddr_ID=0, npc_ID=0, valid_ID=0, fetch_count=0.
  - A pending redirect is discarded.
- Combinational outputs: imemaddr=pc; imemREN=1 in RUN and REDIR_PEND, 0 in HALTED.
- Bubble means instr_ID=0 (nop), valid_ID=0, imemaddr_ID=0, npc_ID=0.
- States: RUN, REDIR_PEND, HALTED.
- Per-cycle priority: RST > halt > redirect > flush > stall > ihit.
- RUN:
  - halt: go to HALTED, IF/ID=bubble, pc held.
  - redirect and ihit: pc<=redirect_pc, IF/ID=bubble, stay RUN; the fetched word is dropped.
  - redirect and !ihit: pend_pc<=redirect_pc, go to REDIR_PEND, IF/ID=bubble, pc held (miss in flight).
  - flush (no redirect): IF/ID=bubble. If ihit and !stall, pc<=pc+4 and the fetched word is dropped; otherwise pc held.
  - stall (no flush/redirect): pc and IF/ID held; a word returned this cycle is dropped and refetched later.
  - ihit, no other event: IF/ID<={imemload, pc, pc+4, 1}; pc<=pc+4; fetch_count+=1.
  - !ihit, no other event: IF/ID=bubble, pc held.
- REDIR_PEND:
  - imemaddr stays at the old pc; IF/ID=bubble every cycle, stall ignored.
  - Another redirect overwrites pend_pc.
  - On ihit: pc<=pend_pc (or redirect_pc if redirect asserted that same cycle), go to RUN, returned word dropped.
  - halt: go to HALTED.
- HALTED: imemREN=0, IF/ID=bubble, pc frozen; only RST exits.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32; no alignment check on redirect_pc.
- fetch_count increments only when valid_ID is written to 1.

Decomposition:
- cpu_types_pkg: word_t (32-bit), fetch_state_t enum {RUN, REDIR_PEND, HALTED}, RESET_PC constant used as the PC_INIT default.
- IF/ID outputs bundled in a fetch_decode_if interface with modport ifid, consumed by the decode stage.
- No sub-module; PC register, FSM and latch live in one module.

Test Plan:
- Reset then ihit=1 for 3 cycles, imemload=A,B,C -> imemaddr 0,4,8; IF/ID gets (A,0,4,1), (B,4,8,1), (C,8,12,1); fetch_count=3.
- ihit=0 for 4 cycles at pc=0x10 -> imemaddr steady 0x10, valid_ID=0 each cycle; ihit=1 -> IF/ID=(imemload,0x10,0x14,1), pc=0x14.
- stall=1 for 2 cycles with ihit=1 at pc=0x20, IF/ID holding 0x1C -> pc stays 0x20, IF/ID unchanged, fetch_count unchanged; release -> 0x20 captured.
- redirect=1, redirect_pc=0x100 with ihit=0 at pc=0x40 -> REDIR_PEND, imemaddr stays 0x40 for 3 miss cycles; ihit -> pc=0x100, valid_ID=0; next fetch at 0x100.
- halt and redirect in the same cycle -> HALTED, imemREN=0, pc unchanged, valid_ID=0 thereafter; RST -> pc=PC_INIT, imemREN=1.
- pc=0xFFFF_FFFC with ihit=1 -> npc_ID=0, pc wraps to 0; flush and ihit in the same cycle -> valid_ID=0, pc advances by 4.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states,
// reset PC and small PC arithmetic helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    localparam word_t RESET_PC = 32'h0000_0000;
    localparam word_t NOP_WORD = 32'h0000_0000;

    // Sequential next PC; wraps modulo 2^32 by construction.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// IF/ID pipeline latch bundle, read by the decode stage through modport ifid.
interface fetch_decode_if;
    import cpu_types_pkg::*;

    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;

    modport ifid  (input  instr, pc, npc, valid);
    modport fetch (output instr, pc, npc, valid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (run / pending redirect /
// halted) and the IF/ID latch. A redirect arriving during an i-cache miss is
// parked in pend_pc so the cache address stays put until the miss resolves.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_ID,
    output logic [31:0] imemaddr_ID,
    output logic [31:0] npc_ID,
    output logic        valid_ID,
    output logic [31:0] fetch_count
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        pend_pc_reg, pend_pc_next;
    word_t        instr_reg, instr_next;
    word_t        addr_id_reg, addr_id_next;
    word_t        npc_id_reg, npc_id_next;
    logic         valid_reg, valid_next;
    word_t        count_reg, count_next;

    fetch_decode_if ifid_bus ();

    // Next-state and IF/ID latch decision; priority halt > redirect > flush > stall > ihit.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pend_pc_next = pend_pc_reg;
        instr_next   = instr_reg;
        addr_id_next = addr_id_reg;
        npc_id_next  = npc_id_reg;
        valid_next   = valid_reg;
        count_next   = count_reg;

        unique case (state_reg)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                    instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
                end else if (redirect) begin
                    instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
                    if (ihit) begin
                        pc_next = redirect_pc;
                    end else begin
                        // Miss in flight: keep the cache address stable, remember the target.
                        pend_pc_next = redirect_pc;
                        state_next   = REDIR_PEND;
                    end
                end else if (flush) begin
                    instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
                    if (ihit && !stall) begin
                        pc_next = pc_plus4(pc_reg);
                    end
                end else if (stall) begin
                    // Hold everything; any word returned now is refetched later.
                end else if (ihit) begin
                    instr_next   = imemload;
                    addr_id_next = pc_reg;
                    npc_id_next  = pc_plus4(pc_reg);
                    valid_next   = 1'b1;
                    pc_next      = pc_plus4(pc_reg);
                    count_next   = count_reg + 32'd1;
                end else begin
                    instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
                end
            end

            REDIR_PEND: begin
                instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
                if (halt) begin
                    state_next = HALTED;
                end else begin
                    if (redirect) begin
                        pend_pc_next = redirect_pc;
                    end
                    if (ihit) begin
                        // Miss resolved: the returned word belongs to the old path and is dropped.
                        pc_next    = redirect ? redirect_pc : pend_pc_reg;
                        state_next = RUN;
                    end
                end
            end

            HALTED: begin
                instr_next = NOP_WORD; addr_id_next = '0; npc_id_next = '0; valid_next = 1'b0;
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State, PC and IF/ID latch registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= RUN;
            pc_reg      <= PC_INIT;
            pend_pc_reg <= '0;
            instr_reg   <= NOP_WORD;
            addr_id_reg <= '0;
            npc_id_reg  <= '0;
            valid_reg   <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pend_pc_reg <= pend_pc_next;
            instr_reg   <= instr_next;
            addr_id_reg <= addr_id_next;
            npc_id_reg  <= npc_id_next;
            valid_reg   <= valid_next;
            count_reg   <= count_next;
        end
    end

    assign ifid_bus.instr = instr_reg;
    assign ifid_bus.pc    = addr_id_reg;
    assign ifid_bus.npc   = npc_id_reg;
    assign ifid_bus.valid = valid_reg;

    assign imemaddr    = pc_reg;
    assign imemREN     = (state_reg != HALTED);
    assign instr_ID    = ifid_bus.instr;
    assign imemaddr_ID = ifid_bus.pc;
    assign npc_ID      = ifid_bus.npc;
    assign valid_ID    = ifid_bus.valid;
    assign fetch_count = count_reg;

endmodule
